// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Valid/ready operand input, valid/ready result output.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic fa_s;
    logic fa_c;
    logic accept;
    logic last_bit;

    // The single full-adder cell shared by every bit position
    always_comb begin
        fa_s = a_sr[0] ^ b_sr[0] ^ carry;
        fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    end

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid)  state_nx = RUN;
            RUN:  if (last_bit)  state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default:             state_nx = IDLE;
        endcase
    end

    // Operand shifters, sum shifter, carry and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            sum_r <= '0;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            sum_r <= {fa_s, sum_r[WIDTH-1:1]};
            carry <= fa_c;
            // Hold at the last index so a power-of-two WIDTH never wraps
            if (!last_bit) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign c_out     = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH = 8.
// Latency, stall, ignored-input and async-reset checks.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic         c_in      = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic         c_out;
    logic [W-1:0] sum;

    int vectors = 0;
    int fails   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction with out_ready held high
    task automatic run_txn(input string tag, input logic [W-1:0] va,
                           input logic [W-1:0] vb, input logic vc,
                           input logic [W-1:0] es, input logic ec);
        a        = va;
        b        = vb;
        c_in     = vc;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        step;
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        repeat (W - 1) step;
        chk({tag, "_early_valid"}, out_valid, 0);
        step;
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_c_out"}, c_out, ec);
        step;
        chk({tag, "_idle"}, in_ready, 1);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_c_out", c_out, 0);
        #10;
        rst_n = 1'b1;

        run_txn("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_txn("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_txn("tffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_txn("t0000", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        run_txn("taa55", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);
        run_txn("t8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        chk("retain_sum", sum, 8'h00);

        // Stall in DONE with in_valid asserted throughout RUN and DONE
        out_ready = 1'b0;
        a         = 8'h12;
        b         = 8'h34;
        c_in      = 1'b0;
        in_valid  = 1'b1;
        step;
        a = 8'h11;
        b = 8'h00;
        repeat (W - 1) step;
        chk("stall_run_busy", busy, 1);
        step;
        chk("stall_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            step;
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_sum", sum, 8'h46);
            chk("stall_hold_c_out", c_out, 0);
            chk("stall_hold_busy", busy, 0);
            chk("stall_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step;
        chk("hs_in_ready", in_ready, 1);
        chk("hs_busy", busy, 0);
        chk("hs_retain_sum", sum, 8'h46);
        step;
        in_valid = 1'b0;
        chk("reaccept_busy", busy, 1);
        repeat (W - 1) step;
        step;
        chk("reaccept_valid", out_valid, 1);
        chk("reaccept_sum", sum, 8'h11);
        chk("reaccept_c_out", c_out, 0);
        step;

        // Short async reset pulse three RUN edges into a transaction
        a        = 8'h5A;
        b        = 8'h3C;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        repeat (3) step;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_sum", sum, 0);
        chk("arst_c_out", c_out, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            step;
            chk("post_rst_no_valid", out_valid, 0);
        end
        run_txn("t0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
